// File: rtl/rv_mem_credit_arb.sv
// rv_mem_credit_arb
// Round-robin arbiter that shares one downstream memory port among NUM_REQS
// requesters. Reads are limited per requester by a credit counter, and the
// requester index is carried in the low bits of the outgoing tag so that
// responses can be routed back.
// Optional feature macro: RV_MEM_ARB_PERF_EN adds the 32-bit
// perf_credit_stalls counter port.
module rv_mem_credit_arb #(
  parameter int NUM_REQS        = 4,
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 26,
  parameter int TAG_IN_WIDTH    = 8,
  parameter int MAX_OUTSTANDING = 8,
  localparam int SEL_BITS       = $clog2(NUM_REQS),
  localparam int TAG_OUT_WIDTH  = TAG_IN_WIDTH + SEL_BITS,
  localparam int CNT_BITS       = $clog2(MAX_OUTSTANDING + 1),
  localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQS-1:0]               req_valid_in,
  input  logic [NUM_REQS-1:0]               req_rw_in,
  input  logic [NUM_REQS*BE_WIDTH-1:0]      req_byteen_in,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]    req_data_in,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]  req_tag_in,
  output logic [NUM_REQS-1:0]               req_ready_in,
  output logic                              req_valid_out,
  output logic                              req_rw_out,
  output logic [BE_WIDTH-1:0]               req_byteen_out,
  output logic [ADDR_WIDTH-1:0]             req_addr_out,
  output logic [DATA_WIDTH-1:0]             req_data_out,
  output logic [TAG_OUT_WIDTH-1:0]          req_tag_out,
  input  logic                              req_ready_out,
  input  logic                              rsp_valid_in,
  input  logic [DATA_WIDTH-1:0]             rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]          rsp_tag_in,
  output logic                              rsp_ready_in,
  output logic [NUM_REQS-1:0]               rsp_valid_out,
  output logic [NUM_REQS*DATA_WIDTH-1:0]    rsp_data_out,
  output logic [NUM_REQS*TAG_IN_WIDTH-1:0]  rsp_tag_out,
  input  logic [NUM_REQS-1:0]               rsp_ready_out,
  output logic                              busy
`ifdef RV_MEM_ARB_PERF_EN
  ,
  output logic [31:0]                       perf_credit_stalls
`endif
);

  localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_OUTSTANDING);

  // Per-requester views of the packed request buses
  logic [BE_WIDTH-1:0]     byteen_a_s [NUM_REQS];
  logic [ADDR_WIDTH-1:0]   addr_a_s   [NUM_REQS];
  logic [DATA_WIDTH-1:0]   data_a_s   [NUM_REQS];
  logic [TAG_IN_WIDTH-1:0] tag_a_s    [NUM_REQS];

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
    assign byteen_a_s[g] = req_byteen_in[g*BE_WIDTH +: BE_WIDTH];
    assign addr_a_s[g]   = req_addr_in[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_a_s[g]   = req_data_in[g*DATA_WIDTH +: DATA_WIDTH];
    assign tag_a_s[g]    = req_tag_in[g*TAG_IN_WIDTH +: TAG_IN_WIDTH];
  end

  // State
  logic [NUM_REQS-1:0][CNT_BITS-1:0] cnt_r;
  logic [SEL_BITS-1:0]               ptr_r;
  logic                              out_valid_r;
  logic                              out_rw_r;
  logic [BE_WIDTH-1:0]               out_byteen_r;
  logic [ADDR_WIDTH-1:0]             out_addr_r;
  logic [DATA_WIDTH-1:0]             out_data_r;
  logic [TAG_OUT_WIDTH-1:0]          out_tag_r;

  // Arbitration signals
  logic [NUM_REQS-1:0] elig_s;
  logic [NUM_REQS-1:0] stall_s;
  logic                can_issue_s;
  logic                found_s;
  logic [SEL_BITS-1:0] win_s;
  logic                grant_s;

  // Response routing signals
  logic [SEL_BITS-1:0] rsp_idx_s;
  logic                rsp_ok_s;
  logic                rsp_fire_s;
  logic [NUM_REQS-1:0] inc_s;
  logic [NUM_REQS-1:0] dec_s;

  // Eligibility: writes always eligible, reads only while credits remain
  always_comb begin
    elig_s  = '0;
    stall_s = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      elig_s[i]  = req_valid_in[i] && (req_rw_in[i] || (cnt_r[i] < MAX_CNT));
      stall_s[i] = req_valid_in[i] && !req_rw_in[i] && (cnt_r[i] == MAX_CNT);
    end
  end

  // The register can take a new request when empty or draining this cycle
  assign can_issue_s = !out_valid_r || req_ready_out;

  // Round-robin search: first eligible index starting at ptr_r, wrapping
  always_comb begin
    int cand_v;
    cand_v  = 0;
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      cand_v = int'(ptr_r) + k;
      if (cand_v >= NUM_REQS) begin
        cand_v = cand_v - NUM_REQS;
      end else begin
        cand_v = cand_v;
      end
      if (!found_s && elig_s[cand_v]) begin
        found_s = 1'b1;
        win_s   = SEL_BITS'(cand_v);
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant_s = can_issue_s && found_s;

  // One-hot ready back to the winning requester only
  always_comb begin
    req_ready_in = '0;
    if (grant_s) begin
      req_ready_in[win_s] = 1'b1;
    end else begin
      req_ready_in = '0;
    end
  end

  // Round-robin pointer moves just past the winner on every grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (grant_s) begin
      if (int'(win_s) == NUM_REQS - 1) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= win_s + 1'b1;
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // One-entry output register: load on grant, clear on drain, else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r  <= 1'b0;
      out_rw_r     <= 1'b0;
      out_byteen_r <= '0;
      out_addr_r   <= '0;
      out_data_r   <= '0;
      out_tag_r    <= '0;
    end else if (grant_s) begin
      out_valid_r  <= 1'b1;
      out_rw_r     <= req_rw_in[win_s];
      out_byteen_r <= byteen_a_s[win_s];
      out_addr_r   <= addr_a_s[win_s];
      out_data_r   <= data_a_s[win_s];
      out_tag_r    <= {tag_a_s[win_s], win_s};
    end else if (req_ready_out) begin
      out_valid_r  <= 1'b0;
    end else begin
      out_valid_r  <= out_valid_r;
    end
  end

  assign req_valid_out  = out_valid_r;
  assign req_rw_out     = out_rw_r;
  assign req_byteen_out = out_byteen_r;
  assign req_addr_out   = out_addr_r;
  assign req_data_out   = out_data_r;
  assign req_tag_out    = out_tag_r;

  // Response routing by the index field; out-of-range indices are sunk
  assign rsp_idx_s = rsp_tag_in[SEL_BITS-1:0];

  // Steer response valid to its owner and take ready from that owner
  always_comb begin
    rsp_valid_out = '0;
    rsp_ready_in  = 1'b1;
    rsp_ok_s      = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (rsp_idx_s == SEL_BITS'(i)) begin
        rsp_ok_s         = 1'b1;
        rsp_ready_in     = rsp_ready_out[i];
        rsp_valid_out[i] = rsp_valid_in;
      end else begin
        rsp_valid_out[i] = 1'b0;
      end
    end
  end

  assign rsp_fire_s   = rsp_valid_in && rsp_ready_in && rsp_ok_s;
  assign rsp_data_out = {NUM_REQS{rsp_data_in}};
  assign rsp_tag_out  = {NUM_REQS{rsp_tag_in[TAG_OUT_WIDTH-1:SEL_BITS]}};

  // Credit take on read grant, credit return on response handshake
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      inc_s[i] = grant_s && (win_s == SEL_BITS'(i)) && !req_rw_in[i];
      dec_s[i] = rsp_fire_s && (rsp_idx_s == SEL_BITS'(i));
    end
  end

  // Credit counters; a return with no credit out saturates at zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (inc_s[i] && !dec_s[i]) begin
          cnt_r[i] <= cnt_r[i] + 1'b1;
        end else if (dec_s[i] && !inc_s[i] && (cnt_r[i] != '0)) begin
          cnt_r[i] <= cnt_r[i] - 1'b1;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  assign busy = (|cnt_r) | out_valid_r;

`ifdef RV_MEM_ARB_PERF_EN
  logic [31:0] perf_stalls_r;

  // Count cycles where some read is held back purely by lack of credit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stalls_r <= 32'd0;
    end else if (|stall_s) begin
      perf_stalls_r <= perf_stalls_r + 32'd1;
    end else begin
      perf_stalls_r <= perf_stalls_r;
    end
  end

  assign perf_credit_stalls = perf_stalls_r;
`else
  logic unused_stall_s;
  assign unused_stall_s = |stall_s;
`endif

endmodule

// File: tb/tb_rv_mem_credit_arb.sv
// Self-checking bench for rv_mem_credit_arb with a reference model of the
// pointer, credits and output register, and a queue of expected requests.
module tb_rv_mem_credit_arb;
  localparam int N    = 4;
  localparam int DW   = 512;
  localparam int AW   = 26;
  localparam int TW   = 8;
  localparam int MAXO = 8;
  localparam int TOW  = 10;
  localparam int BEW  = 64;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]     req_valid_in, req_rw_in, req_ready_in;
  logic [N*BEW-1:0] req_byteen_in;
  logic [N*AW-1:0]  req_addr_in;
  logic [N*DW-1:0]  req_data_in;
  logic [N*TW-1:0]  req_tag_in;
  logic             req_valid_out, req_rw_out, req_ready_out;
  logic [BEW-1:0]   req_byteen_out;
  logic [AW-1:0]    req_addr_out;
  logic [DW-1:0]    req_data_out;
  logic [TOW-1:0]   req_tag_out;
  logic             rsp_valid_in, rsp_ready_in;
  logic [DW-1:0]    rsp_data_in;
  logic [TOW-1:0]   rsp_tag_in;
  logic [N-1:0]     rsp_valid_out, rsp_ready_out;
  logic [N*DW-1:0]  rsp_data_out;
  logic [N*TW-1:0]  rsp_tag_out;
  logic             busy;
`ifdef RV_MEM_ARB_PERF_EN
  logic [31:0]      perf_credit_stalls;
`endif

  rv_mem_credit_arb dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in),
    .req_byteen_in(req_byteen_in), .req_addr_in(req_addr_in),
    .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out), .req_rw_out(req_rw_out),
    .req_byteen_out(req_byteen_out), .req_addr_out(req_addr_out),
    .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_data_in(rsp_data_in),
    .rsp_tag_in(rsp_tag_in), .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out),
    .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out),
    .busy(busy)
`ifdef RV_MEM_ARB_PERF_EN
    ,
    .perf_credit_stalls(perf_credit_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]  addr;
    logic [TOW-1:0] tag;
    logic           rw;
    logic [DW-1:0]  data;
    logic [BEW-1:0] be;
  } req_t;

  req_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int          m_ptr;
  int          m_cnt [N];
  logic        m_out_valid;
  logic [31:0] m_perf;
  int          seq [N];

  function automatic int model_win();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid_in[idx] && (req_rw_in[idx] || m_cnt[idx] < MAXO)) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_out_valid = 1'b0;
    m_perf = 32'd0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    q.delete();
  endtask

  task automatic set_slice(input int i);
    req_addr_in[i*AW +: AW] = {2'(i), 24'(seq[i])};
    req_tag_in[i*TW +: TW]  = 8'((seq[i] * 4 + i) & 255);
  endtask

  // One clock: predict grant, push the expected request, update the model
  task automatic advance();
    int   w, ridx;
    logic g, fire;
    req_t it;
    w    = model_win();
    g    = (w >= 0) && (!m_out_valid || req_ready_out);
    ridx = int'(rsp_tag_in[1:0]);
    fire = rsp_valid_in && rsp_ready_out[ridx];
    if (g) begin
      it.addr = req_addr_in[w*AW +: AW];
      it.tag  = {req_tag_in[w*TW +: TW], 2'(w)};
      it.rw   = req_rw_in[w];
      it.data = req_data_in[w*DW +: DW];
      it.be   = req_byteen_in[w*BEW +: BEW];
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (req_valid_in[i] && !req_rw_in[i] && m_cnt[i] == MAXO) begin
        m_perf = m_perf + 32'd1;
        break;
      end
    end
    for (int i = 0; i < N; i++) begin
      logic inc, dec;
      inc = g && (w == i) && !req_rw_in[i];
      dec = fire && (ridx == i);
      if (inc && !dec) m_cnt[i] = m_cnt[i] + 1;
      else if (dec && !inc && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
    end
    if (g) begin
      q.push_back(it);
      m_ptr = (w + 1) % N;
      m_out_valid = 1'b1;
    end else if (req_ready_out) begin
      m_out_valid = 1'b0;
    end
    @(negedge clk);
    if (g) begin
      seq[w] = seq[w] + 1;
      set_slice(w);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid_in = '0; req_rw_in = '0; req_ready_out = 1'b1;
    rsp_valid_in = 1'b0; rsp_tag_in = '0; rsp_ready_out = '0;
    rsp_data_in = {16{32'hC0DE_0000}};
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      set_slice(i);
      req_data_in[i*DW +: DW]    = {16{32'hD000_0000 + 32'(i)}};
      req_byteen_in[i*BEW +: BEW] = {16{4'(i + 1)}};
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (req_valid_out !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_valid_busy: got valid=%b busy=%b want 0 0", req_valid_out, busy);
    end
    total++;
    if (rsp_valid_out !== 4'b0000 || req_ready_in !== 4'b0000) begin
      bad++; $display("FAIL reset_idle: got rsp_valid_out=%b req_ready_in=%b want 0000 0000", rsp_valid_out, req_ready_in);
    end
    total++;
    if (req_addr_out !== '0 || req_tag_out !== '0 || req_data_out !== '0 || req_byteen_out !== '0) begin
      bad++; $display("FAIL reset_fields: got addr=%h tag=%h want 0", req_addr_out, req_tag_out);
    end
    advance(); advance();
    #1;
    total++;
    if (req_ready_in !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL idle: got req_ready_in=%b busy=%b want 0000 0", req_ready_in, busy);
    end
  endtask

  task automatic test_round_robin();
    req_t e;
    req_valid_in = 4'b1111; req_rw_in = 4'b0000; req_ready_out = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      total++;
      if (req_ready_in !== 4'(1 << (k % 4))) begin
        bad++; $display("FAIL rr_grant: cycle %0d got %b want %b", k, req_ready_in, 4'(1 << (k % 4)));
      end
      if (req_valid_out && req_ready_out) begin
        total++;
        e = q.pop_front();
        if (req_addr_out !== e.addr || req_tag_out !== e.tag || req_rw_out !== e.rw ||
            req_data_out !== e.data || req_byteen_out !== e.be || req_tag_out[1:0] !== 2'((k + 3) % 4)) begin
          bad++; $display("FAIL rr_out: got addr=%h tag=%h want addr=%h tag=%h", req_addr_out, req_tag_out, e.addr, e.tag);
        end
      end
      if (k > 0) begin
        total++;
        if (req_valid_out !== 1'b1 || busy !== 1'b1) begin
          bad++; $display("FAIL rr_latency: got valid=%b busy=%b want 1 1", req_valid_out, busy);
        end
      end
      advance();
    end
    req_valid_in = 4'b0000;
    #1;
    if (req_valid_out && req_ready_out) begin
      total++;
      e = q.pop_front();
      if (req_addr_out !== e.addr || req_tag_out !== e.tag) begin
        bad++; $display("FAIL rr_last: got addr=%h tag=%h want addr=%h tag=%h", req_addr_out, req_tag_out, e.addr, e.tag);
      end
    end
    advance();
    #1;
    total++;
    if (req_valid_out !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL rr_drain: got valid=%b busy=%b want 0 1", req_valid_out, busy);
    end
  endtask

  task automatic test_credit_limit();
    req_t e;
    req_valid_in = 4'b0100; req_rw_in = 4'b0000; req_ready_out = 1'b1;
    for (int n = 0; n < 20 && m_cnt[2] < MAXO; n++) begin
      #1;
      total++;
      if (req_ready_in !== 4'b0100) begin
        bad++; $display("FAIL credit_fill: got %b want 0100", req_ready_in);
      end
      if (req_valid_out) begin
        total++;
        e = q.pop_front();
        if (req_addr_out !== e.addr || req_tag_out !== e.tag) begin
          bad++; $display("FAIL credit_out: got addr=%h tag=%h want addr=%h tag=%h", req_addr_out, req_tag_out, e.addr, e.tag);
        end
      end
      advance();
    end
    #1;
    total++;
    if (req_ready_in !== 4'b0000 || int'(dut.cnt_r[2]) !== MAXO) begin
      bad++; $display("FAIL credit_stall: got ready=%b cnt=%0d want 0000 %0d", req_ready_in, dut.cnt_r[2], MAXO);
    end
    if (req_valid_out) begin
      total++;
      e = q.pop_front();
      if (req_addr_out !== e.addr || req_tag_out !== e.tag) begin
        bad++; $display("FAIL credit_last: got addr=%h want %h", req_addr_out, e.addr);
      end
    end
    advance();
    req_rw_in = 4'b0100;
    #1;
    total++;
    if (req_ready_in !== 4'b0100) begin
      bad++; $display("FAIL credit_write: got %b want 0100", req_ready_in);
    end
    advance();
    req_rw_in = 4'b0000;
    #1;
    total++;
    e = q.pop_front();
    if (req_valid_out !== 1'b1 || req_rw_out !== 1'b1 || req_addr_out !== e.addr || req_ready_in !== 4'b0000) begin
      bad++; $display("FAIL credit_write_out: got valid=%b rw=%b ready=%b want 1 1 0000", req_valid_out, req_rw_out, req_ready_in);
    end
    advance();
    rsp_valid_in = 1'b1; rsp_tag_in = {8'h33, 2'd2}; rsp_ready_out = 4'b1111;
    #1;
    total++;
    if (req_ready_in !== 4'b0000 || rsp_valid_out !== 4'b0100 || rsp_ready_in !== 1'b1) begin
      bad++; $display("FAIL credit_rsp: got ready=%b rsp_valid_out=%b rsp_ready_in=%b want 0000 0100 1", req_ready_in, rsp_valid_out, rsp_ready_in);
    end
    advance();
    rsp_valid_in = 1'b0;
    #1;
    total++;
    if (req_ready_in !== 4'b0100) begin
      bad++; $display("FAIL credit_regrant: got %b want 0100", req_ready_in);
    end
    advance();
    req_valid_in = 4'b0000;
    #1;
    e = q.pop_front();
    total++;
    if (req_addr_out !== e.addr || req_tag_out !== e.tag || req_rw_out !== 1'b0) begin
      bad++; $display("FAIL credit_regrant_out: got addr=%h tag=%h want addr=%h tag=%h", req_addr_out, req_tag_out, e.addr, e.tag);
    end
    advance();
`ifdef RV_MEM_ARB_PERF_EN
    total++;
    if (perf_credit_stalls !== m_perf || perf_credit_stalls == 32'd0) begin
      bad++; $display("FAIL perf_stalls: got %0d want %0d (nonzero)", perf_credit_stalls, m_perf);
    end
`endif
  endtask

  task automatic test_backpressure();
    req_t e, f;
    int   w;
    req_valid_in = 4'b1111; req_rw_in = 4'b1111; req_ready_out = 1'b1;
    #1;
    advance();
    req_ready_out = 1'b0;
    #1;
    f = q[0];
    for (int k = 0; k < 5; k++) begin
      total++;
      if (req_ready_in !== 4'b0000 || req_valid_out !== 1'b1 || req_addr_out !== f.addr ||
          req_tag_out !== f.tag || req_data_out !== f.data || req_byteen_out !== f.be) begin
        bad++; $display("FAIL bp_hold: cycle %0d ready=%b valid=%b addr=%h want 0000 1 %h", k, req_ready_in, req_valid_out, req_addr_out, f.addr);
      end
      advance();
      #1;
    end
    req_ready_out = 1'b1;
    #1;
    w = model_win();
    total++;
    if (w < 0 || req_ready_in !== 4'(1 << w)) begin
      bad++; $display("FAIL bp_release: got %b want grant to %0d", req_ready_in, w);
    end
    e = q.pop_front();
    total++;
    if (req_addr_out !== e.addr || req_tag_out !== e.tag) begin
      bad++; $display("FAIL bp_out: got addr=%h want %h", req_addr_out, e.addr);
    end
    advance();
    req_valid_in = 4'b0000; req_rw_in = 4'b0000;
    #1;
    e = q.pop_front();
    total++;
    if (req_addr_out !== e.addr || req_tag_out !== e.tag) begin
      bad++; $display("FAIL bp_next: got addr=%h want %h", req_addr_out, e.addr);
    end
    advance();
  endtask

  task automatic test_rsp_routing();
    int pre;
    pre = m_cnt[1];
    rsp_valid_in = 1'b1; rsp_tag_in = {8'h5A, 2'd1}; rsp_ready_out = 4'b0010;
    rsp_data_in = {16{32'hFACE_B00C}};
    #1;
    total++;
    if (rsp_valid_out !== 4'b0010 || rsp_ready_in !== 1'b1 || rsp_tag_out[15:8] !== 8'h5A) begin
      bad++; $display("FAIL rsp_route: got valid=%b ready=%b tag=%h want 0010 1 5a", rsp_valid_out, rsp_ready_in, rsp_tag_out[15:8]);
    end
    total++;
    if (rsp_data_out[DW +: DW] !== {16{32'hFACE_B00C}}) begin
      bad++; $display("FAIL rsp_data: got %h want facebOOc pattern", rsp_data_out[DW +: 32]);
    end
    advance();
    #1;
    total++;
    if (int'(dut.cnt_r[1]) !== pre - 1) begin
      bad++; $display("FAIL rsp_credit: got %0d want %0d", dut.cnt_r[1], pre - 1);
    end
    rsp_ready_out = 4'b1101;
    #1;
    total++;
    if (rsp_ready_in !== 1'b0 || rsp_valid_out !== 4'b0010) begin
      bad++; $display("FAIL rsp_block: got ready=%b valid=%b want 0 0010", rsp_ready_in, rsp_valid_out);
    end
    advance();
    #1;
    total++;
    if (int'(dut.cnt_r[1]) !== pre - 1) begin
      bad++; $display("FAIL rsp_noacc: got %0d want %0d", dut.cnt_r[1], pre - 1);
    end
    rsp_valid_in = 1'b0; rsp_ready_out = 4'b0000;
  endtask

  task automatic test_same_cycle_and_reset();
    total++;
    if (int'(dut.cnt_r[0]) !== 3 || m_cnt[0] != 3) begin
      bad++; $display("FAIL pre_cnt0: got %0d want 3", dut.cnt_r[0]);
    end
    req_valid_in = 4'b0001; req_rw_in = 4'b0000; req_ready_out = 1'b1;
    rsp_valid_in = 1'b1; rsp_tag_in = {8'h11, 2'd0}; rsp_ready_out = 4'b0001;
    #1;
    total++;
    if (req_ready_in !== 4'b0001 || rsp_ready_in !== 1'b1) begin
      bad++; $display("FAIL same_cycle_hs: got ready=%b rsp_ready=%b want 0001 1", req_ready_in, rsp_ready_in);
    end
    advance();
    rsp_valid_in = 1'b0;
    req_valid_in = 4'b1111;
    #1;
    total++;
    if (int'(dut.cnt_r[0]) !== 3) begin
      bad++; $display("FAIL same_cycle_cnt: got %0d want 3", dut.cnt_r[0]);
    end
    advance();
    advance();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (req_valid_out !== 1'b0 || busy !== 1'b0 || dut.cnt_r !== '0) begin
      bad++; $display("FAIL async_reset: got valid=%b busy=%b cnt=%h want 0 0 0", req_valid_out, busy, dut.cnt_r);
    end
    req_valid_in = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (req_ready_in !== 4'b0000 || req_valid_out !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL post_reset: got ready=%b valid=%b busy=%b want 0000 0 0", req_ready_in, req_valid_out, busy);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_credit_limit();
    test_backpressure();
    test_rsp_routing();
    test_same_cycle_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/rv_mem_credit_arb.md
Name: rv_mem_credit_arb

Overview:
- Round-robin arbiter that shares one downstream memory port among NUM_REQS upstream requesters (cores or L1 caches).
- Enforces a per-requester cap on outstanding reads using credit counters.
- Appends the requester index to the outgoing tag and uses it to route responses back to the right requester.
- Sits between the per-core memory ports and the cluster/L2 memory interface.

Parameters:
NUM_REQS, 4, number of upstream requesters (>=2)
DATA_WIDTH, 512, memory data width in bits
ADDR_WIDTH, 26, memory line address width
TAG_IN_WIDTH, 8, upstream tag width
MAX_OUTSTANDING, 8, max in-flight reads per requester (>=1)
(localparam) SEL_BITS = clog2(NUM_REQS); TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_BITS; CNT_BITS = clog2(MAX_OUTSTANDING+1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
req_valid_in  in  NUM_REQS  per-requester request valid
req_rw_in  in  NUM_REQS  1=write, 0=read
req_byteen_in  in  NUM_REQS*DATA_WIDTH/8  byte enables, packed, requester i at slice i
req_addr_in  in  NUM_REQS*ADDR_WIDTH  addresses, packed
req_data_in  in  NUM_REQS*DATA_WIDTH  write data, packed
req_tag_in  in  NUM_REQS*TAG_IN_WIDTH  tags, packed
req_ready_in  out  NUM_REQS  request accepted from requester i
req_valid_out  out  1  downstream request valid
req_rw_out  out  1  downstream rw
req_byteen_out  out  DATA_WIDTH/8  downstream byte enables
req_addr_out  out  ADDR_WIDTH  downstream address
req_data_out  out  DATA_WIDTH  downstream write data
req_tag_out  out  TAG_OUT_WIDTH  {tag_in, requester index}; index in the SEL_BITS LSBs
req_ready_out  in  1  downstream accepts the request
rsp_valid_in  in  1  downstream response valid
rsp_data_in  in  DATA_WIDTH  response data
rsp_tag_in  in  TAG_OUT_WIDTH  response tag
rsp_ready_in  out  1  arbiter accepts the response
rsp_valid_out  out  NUM_REQS  per-requester response valid
rsp_data_out  out  NUM_REQS*DATA_WIDTH  response data, replicated to all slices
rsp_tag_out  out  NUM_REQS*TAG_IN_WIDTH  rsp_tag_in[TAG_OUT_WIDTH-1:SEL_BITS], replicated
rsp_ready_out  in  NUM_REQS  requester i accepts its response
busy  out  1  reads in flight or request register occupied

Behaviour:
- Reset values:
  - Output register valid = 0, so req_valid_out = 0.
  - All credit counters = 0; RR pointer = 0; busy = 0.
  - req_*_out data fields = 0.
  - rsp_valid_out = 0 until rsp_valid_in is asserted.
- Eligibility: requester i is eligible when req_valid_in[i] && (req_rw_in[i] || cnt[i] < MAX_OUTSTANDING).
- Grant:
  - Issued when eligible requesters exist and the output register is empty or draining this cycle (req_valid_out && req_ready_out).
  - The winner is the first eligible index searching from ptr upward, with wrap-around.
  - req_ready_in is one-hot on the winner; all other bits are 0.
  - Combinational path from req_valid_in to req_ready_in is allowed; there is no path from req_ready_out to req_valid_out.
- RR pointer: on a grant to index w, ptr <= (w+1) mod NUM_REQS. With no grant, ptr holds.
- Request latency: exactly 1 cycle. The granted request is captured in a one-entry register and appears on req_*_out next cycle. It is held stable while req_valid_out && !req_ready_out.
- Credits:
  - cnt[i] increments when a read from i is granted.
  - cnt[i] decrements on a response handshake (rsp_valid_in && rsp_ready_in) whose index field = i.
  - Both in the same cycle: cnt[i] is unchanged.
  - Writes consume no credit and generate no response.
- Credit boundaries:
  - At cnt[i] == MAX_OUTSTANDING, reads from i are not granted; writes from i still are.
  - A response arriving while cnt[i] == 0 is a protocol error. The counter saturates at 0.
- Response routing: purely combinational, 0 latency.
  - idx = rsp_tag_in[SEL_BITS-1:0].
  - rsp_valid_out[idx] = rsp_valid_in; all other bits are 0.
  - rsp_ready_in = rsp_ready_out[idx].
  - An idx >= NUM_REQS is dropped (rsp_ready_in = 1, no valid out, no counter change).
- busy = (|cnt) | req_valid_out.
- Reset mid-operation clears the register, counters and pointer immediately (async). In-flight responses after reset are not tracked.

Optional Feature:
RV_MEM_ARB_PERF_EN:
- When defined, adds output port perf_credit_stalls (32 bits, reset 0).
- It increments, with wrap at 2^32, each cycle in which some requester has req_valid_in=1 and rw=0, has cnt == MAX_OUTSTANDING, and is therefore ineligible.
- When not defined, the port and counter are absent. Behaviour is otherwise identical.

Test Plan:
1. Reset, then idle: req_valid_out=0, busy=0, rsp_valid_out=0000, req_ready_in=0000 with no valid inputs.
2. All 4 requesters issue reads continuously, req_ready_out=1: grants go 0,1,2,3,0...; req_tag_out LSBs match; each request appears on req_*_out 1 cycle after its grant; busy=1.
3. Requester 2 issues 8 reads with no responses (MAX=8): the 9th read is stalled (req_ready_in[2]=0) while requester 2 writes are still granted. One response with tag index 2 is returned; the read is granted the next cycle. With PERF_EN, the counter is >0.
4. req_ready_out=0 for 5 cycles with req_valid_out=1: output fields stay stable, req_ready_in=0000. On release, the next grant follows in the same cycle.
5. Response with rsp_tag_in={8'h5A, 2'd1} and rsp_ready_out=0010: rsp_valid_out=0010, rsp_tag_out slice 1=8'h5A, rsp_ready_in=1, cnt[1] decremented. The same response with rsp_ready_out=1101 gives rsp_ready_in=0.
6. Read grant to requester 0 and response to requester 0 in the same cycle with cnt[0]=3: cnt[0] stays 3. Async reset asserted mid-burst: cnt=0, req_valid_out=0 and busy=0 immediately.
